fp_norm_lzc_pipe: RTL

//  Pipelined, parametrised normaliser for the FP32 MAC datapath. Sits between the

---
 rtl/fp_norm_lzc_pipe_pkg.sv | 18 +
 rtl/fp_norm_lzc_pipe_lzc_tree.sv | 50 +++++
 rtl/fp_norm_lzc_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_norm_lzc_pipe_pkg.sv
// Shared constants for the FP32 MAC normaliser: field widths, bias and the legacy count offset.
package fp_norm_lzc_pipe_pkg;

    localparam int unsigned FP32_EXP_W    = 8;
    localparam int unsigned FP32_MANT_W   = 23;
    localparam int unsigned EXP_BIAS      = 127;
    localparam int unsigned LEGACY_OFFSET = 1;

    function automatic int unsigned clog2_fn(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_norm_lzc_pipe_lzc_tree.sv
// Combinational leading-zero counter: pads to a power of two with ones, then merges
// (valid, count) pairs level by level from the leaves up.
module fp_norm_lzc_pipe_lzc_tree
    import fp_norm_lzc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned CNT_W = clog2_fn(WIDTH + 2)
) (
    input  logic [WIDTH-1:0] mant_i,
    output logic [CNT_W-1:0] lz_o,
    output logic             all_zero_o
);

    localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PAD_W  = 1 << LEVELS;

    logic [PAD_W-1:0]  padded;
    logic              vld [LEVELS+1][PAD_W];
    logic [LEVELS-1:0] cnt [LEVELS+1][PAD_W];

    // Ones in the pad bits keep the padded count equal to WIDTH for an all-zero input.
    always_comb begin
        padded = '1;
        padded[PAD_W-1 -: WIDTH] = mant_i;
    end

    for (genvar j = 0; j < PAD_W; j++) begin : g_leaf
        assign vld[0][j] = padded[PAD_W-1-j];
        assign cnt[0][j] = '0;
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar j = 0; j < PAD_W; j++) begin : g_node
            if (j < (PAD_W >> (l + 1))) begin : g_merge
                assign vld[l+1][j] = vld[l][2*j] | vld[l][2*j+1];
                assign cnt[l+1][j] = vld[l][2*j] ? cnt[l][2*j]
                                                 : (cnt[l][2*j+1] | LEVELS'(1 << l));
            end else begin : g_idle
                assign vld[l+1][j] = 1'b0;
                assign cnt[l+1][j] = '0;
            end
        end
    end

    always_comb begin
        all_zero_o = ~|mant_i;
        lz_o       = all_zero_o ? CNT_W'(WIDTH) : CNT_W'(cnt[LEVELS][0]);
    end

endmodule

// File: rtl/fp_norm_lzc_pipe.sv
// Pipelined mantissa normaliser: counts leading zeros, shifts the MSB to the top and adjusts
// the exponent, with valid/ready flow control through one or two register stages.
module fp_norm_lzc_pipe
    import fp_norm_lzc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH       = 48,
    parameter int unsigned CNT_W       = clog2_fn(WIDTH + 2),
    parameter int unsigned EXP_W       = 10,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned OFFSET      = LEGACY_OFFSET
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [CNT_W-1:0] lz_cnt,
    output logic             out_zero,
    output logic             out_uflow
);

    localparam int unsigned DIFF_W = EXP_W + 2;

    function automatic logic [WIDTH-1:0] barrel_shl(input logic [WIDTH-1:0] m,
                                                    input logic [CNT_W-1:0] sh);
        logic [WIDTH-1:0] r;
        r = m;
        for (int i = 0; i < CNT_W; i++) begin
            if (sh[i]) r = r << (1 << i);
        end
        return r;
    endfunction

    logic [CNT_W-1:0]  tree_lz;
    logic              tree_zero;

    logic [WIDTH-1:0]  src_mant;
    logic [EXP_W-1:0]  src_exp;
    logic [CNT_W-1:0]  src_lz;
    logic              src_zero;
    logic              load_out;

    logic [DIFF_W-1:0] exp_diff;
    logic [WIDTH-1:0]  res_mant;
    logic [EXP_W-1:0]  res_exp;
    logic [CNT_W-1:0]  res_cnt;
    logic              res_uflow;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_mant_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [CNT_W-1:0]  lz_cnt_q;
    logic              out_zero_q;
    logic              out_uflow_q;
    logic              out_free;

    fp_norm_lzc_pipe_lzc_tree #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lzc_tree (
        .mant_i     (in_mant),
        .lz_o       (tree_lz),
        .all_zero_o (tree_zero)
    );

    assign out_free = !out_valid_q || out_ready;

    if (PIPE_STAGES == 1) begin : g_one_stage
        assign in_ready = rst_n && out_free;
        assign load_out = in_valid && in_ready;
        assign src_mant = in_mant;
        assign src_exp  = in_exp;
        assign src_lz   = tree_lz;
        assign src_zero = tree_zero;
    end else begin : g_two_stage
        logic             s0_valid_q;
        logic [WIDTH-1:0] s0_mant_q;
        logic [EXP_W-1:0] s0_exp_q;
        logic [CNT_W-1:0] s0_lz_q;
        logic             s0_zero_q;
        logic             s0_adv;

        assign s0_adv   = s0_valid_q && out_free;
        assign in_ready = rst_n && (!s0_valid_q || s0_adv);
        assign load_out = s0_adv;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s0_valid_q <= 1'b0;
                s0_mant_q  <= '0;
                s0_exp_q   <= '0;
                s0_lz_q    <= '0;
                s0_zero_q  <= 1'b0;
            end else if (in_valid && in_ready) begin
                s0_valid_q <= 1'b1;
                s0_mant_q  <= in_mant;
                s0_exp_q   <= in_exp;
                s0_lz_q    <= tree_lz;
                s0_zero_q  <= tree_zero;
            end else if (s0_adv) begin
                s0_valid_q <= 1'b0;
            end
        end

        assign src_mant = s0_mant_q;
        assign src_exp  = s0_exp_q;
        assign src_lz   = s0_lz_q;
        assign src_zero = s0_zero_q;
    end

    // Two guard bits so a negative in_exp minus a large count still compares correctly.
    always_comb begin
        exp_diff  = {{2{src_exp[EXP_W-1]}}, src_exp} - DIFF_W'(src_lz);
        res_mant  = src_zero ? '0 : barrel_shl(src_mant, src_lz);
        res_exp   = src_zero ? '0 : exp_diff[EXP_W-1:0];
        res_uflow = !src_zero && (signed'(exp_diff) <= 0);
        res_cnt   = src_lz + CNT_W'(OFFSET);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            lz_cnt_q    <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_mant_q  <= res_mant;
            out_exp_q   <= res_exp;
            lz_cnt_q    <= res_cnt;
            out_zero_q  <= src_zero;
            out_uflow_q <= res_uflow;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign lz_cnt    = lz_cnt_q;
    assign out_zero  = out_zero_q;
    assign out_uflow = out_uflow_q;

endmodule
